// File: rtl/cdc_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared types and constants for the req/ack bundled-data crossing blocks.
//   cdc_hs_state_e      : transmit-side handshake FSM states
//   CDC_MIN_SYNC_DEPTH  : smallest synchronizer depth treated as metastability-safe
// ---------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_hs_state_e;

  localparam int CDC_MIN_SYNC_DEPTH = 2;

endpackage

// File: rtl/cdc_sync_ah.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cdc_sync_ah
// Single-bit flop-chain synchronizer with asynchronous active-high reset to 0.
// Ports:
//   clk  in  1  destination (sampling) clock
//   rst  in  1  asynchronous active-high reset
//   d_i  in  1  asynchronous input bit
//   q_o  out 1  d_i delayed through SYNC_DEPTH flops
// ---------------------------------------------------------------------------
module cdc_sync_ah
  import cdc_pkg::*;
#(
  parameter int SYNC_DEPTH = CDC_MIN_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_d;
  logic [SYNC_DEPTH-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_hs_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cdc_hs_tx
// Source end of a 4-phase req/ack bundled-data clock-domain crossing.
// A word accepted on valid_i/ready_o is held on data_o while req_o is raised;
// the destination samples data_o and answers on ack_i, which is synchronized
// here before it steers the FSM.
// Ports:
//   clk         in   1       source-domain clock
//   rst         in   1       asynchronous active-high reset
//   valid_i     in   1       local word valid
//   data_i      in   DATA_W  local word
//   ready_o     out  1       word can be accepted this cycle
//   req_o       out  1       registered request to the destination domain
//   data_o      out  DATA_W  bundled data, stable while req_o=1
//   ack_i       in   1       asynchronous acknowledge from the destination
//   busy_o      out  1       transfer in flight
//   err_o       out  1       sticky ack-edge timeout flag
//   err_clr_i   in   1       clears err_o
//   xfer_cnt_o  out  CNT_W   completed transfers, wraps silently
// ---------------------------------------------------------------------------
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SYNC_DEPTH = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [CNT_W-1:0]  xfer_cnt_o
);

  localparam int             TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  if (SYNC_DEPTH < CDC_MIN_SYNC_DEPTH) begin : g_bad_sync_depth
    $error("cdc_hs_tx: SYNC_DEPTH must be >= CDC_MIN_SYNC_DEPTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cdc_hs_tx: TIMEOUT must be >= 1");
  end

  cdc_hs_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ready_c;
  logic              tmo_evt;
  logic              ack_s;

  // ack_i is only ever observed through this synchronizer.
  cdc_sync_ah #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_i),
    .q_o (ack_s)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    xfer_d  = xfer_q;
    ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A destination still holding ack (e.g. after a reset mid-transfer)
        // must lower it before a new request may start.
        ready_c = ~ack_s;
        if (valid_i && ready_c) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          xfer_d  = xfer_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Timeout: restarts on every state change, counts while waiting for an
  // ack edge and parks at TIMEOUT. Only the arrival at TIMEOUT raises err,
  // so a clear while still stuck waiting does not re-assert it.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == REQ || state_q == REL) && tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end

    tmo_evt = (tmo_d == TMO_MAX) && (tmo_q != TMO_MAX);

    err_d = err_q;
    if (tmo_evt) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ready_o    = ready_c & ~rst;
  assign req_o      = req_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign xfer_cnt_o = xfer_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
`timescale 1ns/1ps
// Bench for cdc_hs_tx: directed sequence with a data scoreboard and an
// ack responder that echoes req_o after a fixed or random delay.
module tb_cdc_hs_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;
  logic [1:0]  xfer_cnt_o;

  // ack source selection
  logic        ack_auto  = 1'b1;
  logic        ack_man   = 1'b0;
  logic        ack_resp  = 1'b0;
  logic        rand_en   = 1'b0;
  int          fixed_dly = 3;
  int          rnd_dly   = 0;
  int          resp_cnt  = 0;

  // bookkeeping
  int          tests = 0;
  int          fails = 0;
  int          acc_n = 0;
  int          pulses = 0;
  logic [31:0] sb[$];
  logic [31:0] held = '0;
  logic        req_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [1:0]  exp_xfer = 2'd0;

  assign ack_i = ack_auto ? ack_resp : ack_man;

  cdc_hs_tx #(
    .DATA_W     (32),
    .SYNC_DEPTH (2),
    .TIMEOUT    (16),
    .CNT_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .req_o      (req_o),
    .data_o     (data_o),
    .ack_i      (ack_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i),
    .xfer_cnt_o (xfer_cnt_o)
  );

  initial forever #5 clk = ~clk;

  // Destination model: ack follows req after a delay (cycles).
  always @(posedge clk) begin
    if (ack_resp != req_o) begin
      if (resp_cnt >= (rand_en ? rnd_dly : fixed_dly)) begin
        ack_resp <= req_o;
        resp_cnt <= 0;
        rnd_dly  <= $urandom_range(0, 20);
      end else begin
        resp_cnt <= resp_cnt + 1;
      end
    end else begin
      resp_cnt <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: record acceptance at the edge, then check outputs on the
  // falling edge against the scoreboard and the transfer-count model.
  task automatic tick();
    logic [31:0] exp_v;
    @(posedge clk);
    if (!rst && valid_i && ready_o) begin
      sb.push_back(data_i);
      acc_n++;
    end
    @(negedge clk);
    if (req_o && !req_prev) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("sb_nonempty_on_req", 64'(sb.size()), 64'd1);
      end else begin
        exp_v = sb.pop_front();
        chk("data_o", 64'(data_o), 64'(exp_v));
      end
      held = data_o;
    end else if (req_o) begin
      chk("data_stable", 64'(data_o), 64'(held));
    end
    if (busy_o) chk("ready_while_busy", 64'(ready_o), 64'd0);
    if (busy_prev && !busy_o) begin
      exp_xfer = exp_xfer + 2'd1;
      chk("xfer_cnt_model", 64'(xfer_cnt_o), 64'(exp_xfer));
    end
    req_prev  = req_o;
    busy_prev = busy_o;
  endtask

  task automatic send(input logic [31:0] d, input bit hold);
    int n0;
    n0 = acc_n;
    valid_i = 1'b1;
    data_i  = d;
    for (int i = 0; i < 300 && acc_n == n0; i++) tick();
    if (acc_n == n0) chk("accept_bound", 64'(acc_n - n0), 64'd1);
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (busy_o || sb.size() != 0); i++) tick();
    if (busy_o) chk("drain_bound", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int tbl[5];
    int p0;
    tbl = '{1, 2, 3, 0, 1};
    rst = 1'b1;
    valid_i = 1'b0;
    data_i = '0;
    err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_xfer", 64'(xfer_cnt_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(ready_o), 64'd1);

    // 1: single transfer, ack echoed after 3 clocks
    fixed_dly = 3;
    send(32'hA5A5_0001, 1'b0);
    chk("t1_req_rise", 64'(req_o), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_data", 64'(data_o), 64'hA5A5_0001);
    drain();
    chk("t1_xfer", 64'(xfer_cnt_o), 64'd1);
    chk("t1_ready", 64'(ready_o), 64'd1);

    // 2: back-to-back, valid held high across 4 words
    p0 = pulses;
    send(32'h1111_0001, 1'b1);
    send(32'h2222_0002, 1'b1);
    send(32'h3333_0003, 1'b1);
    send(32'h4444_0004, 1'b1);
    valid_i = 1'b0;
    drain();
    chk("t2_pulses", 64'(pulses - p0), 64'd4);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    chk("t2_xfer", 64'(xfer_cnt_o), 64'd1);
    chk("t2_err", 64'(err_o), 64'd0);

    // 3: ack withheld -> timeout after 16 cycles in REQ, no abort
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    send(32'h0000_0033, 1'b0);
    repeat (15) tick();
    chk("t3_err_early", 64'(err_o), 64'd0);
    tick();
    chk("t3_err_set", 64'(err_o), 64'd1);
    chk("t3_req_held", 64'(req_o), 64'd1);
    repeat (5) tick();
    chk("t3_req_still", 64'(req_o), 64'd1);
    ack_man = 1'b1;
    for (int i = 0; i < 50 && req_o; i++) tick();
    chk("t3_req_drop", 64'(req_o), 64'd0);
    ack_man = 1'b0;
    drain();
    chk("t3_err_sticky", 64'(err_o), 64'd1);
    chk("t3_xfer", 64'(xfer_cnt_o), 64'd2);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t3_err_clr", 64'(err_o), 64'd0);

    // 4: reset while in REQ with ack high
    send(32'h0000_0044, 1'b0);
    ack_man = 1'b1;
    tick();
    chk("t4_in_req", 64'(req_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("t4_req_async", 64'(req_o), 64'd0);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_ready_rst", 64'(ready_o), 64'd0);
    chk("t4_xfer", 64'(xfer_cnt_o), 64'd0);
    sb.delete();
    exp_xfer  = 2'd0;
    req_prev  = 1'b0;
    busy_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("t4_ready_blocked", 64'(ready_o), 64'd0);
    ack_man = 1'b0;
    repeat (3) tick();
    chk("t4_ready_back", 64'(ready_o), 64'd1);

    // 5: 2-bit counter wrap
    ack_auto  = 1'b1;
    fixed_dly = 1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      send(32'h5000_0000 + 32'(i), 1'b0);
      drain();
      chk("t5_xfer", 64'(xfer_cnt_o), 64'(tbl[i]));
    end

    // 6: 1000 transfers with random ack delays
    rand_en = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 1000; i++) send($urandom, 1'b1);
    valid_i = 1'b0;
    drain();
    chk("t6_pulses", 64'(pulses - p0), 64'd1000);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
